// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with optional accumulator and result flags.
// Latency: 2 cycles from accept to out_valid; one result per cycle with out_ready high.
// Backpressure: each stage holds while downstream is full; in_ready is combinational from out_ready.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CW-1:0]    popcnt,
    output logic [WIDTH-1:0] acc
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ones;
        logic             parity;
        logic [CW-1:0]    popcnt;
    } s2_t;

    logic             s1_vld;
    logic             s2_vld;
    logic [WIDTH-1:0] s1_res;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] f_res;
    s2_t              s2_q;
    s2_t              s2_d;
    logic             s2_take;
    logic             s1_take;
    logic             accept;

    assign s2_take  = !s2_vld || out_ready;
    assign s1_take  = !s1_vld || s2_take;
    assign in_ready = rst_n && s1_take;
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_eff = use_acc ? acc_q : a;
        f_res = '0;
        case (op)
            3'b000: f_res = a_eff & b;
            3'b001: f_res = a_eff | b;
            3'b010: f_res = a_eff ^ b;
            3'b011: f_res = ~(a_eff & b);
            3'b100: f_res = ~(a_eff | b);
            3'b101: f_res = ~(a_eff ^ b);
            3'b110: f_res = ~a_eff;
            3'b111: f_res = b;
        endcase
    end

    // Flags are derived from the S1 value so they land in S2 together with it.
    always_comb begin
        s2_d        = '0;
        s2_d.res    = s1_res;
        s2_d.zero   = (s1_res == '0);
        s2_d.ones   = &s1_res;
        s2_d.parity = ^s1_res;
        for (int i = 0; i < WIDTH; i++) begin
            s2_d.popcnt = s2_d.popcnt + CW'(s1_res[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_res <= '0;
            s2_q   <= '0;
            acc_q  <= '0;
        end else begin
            if (s1_take) begin
                s1_vld <= accept;
                if (accept) begin
                    s1_res <= f_res;
                end
            end
            // Accumulator commits on the accept edge so a dependent request next cycle sees it.
            if (accept && acc_wr) begin
                acc_q <= f_res;
            end
            if (s2_take) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign out_valid = s2_vld;
    assign result    = s2_q.res;
    assign zero      = s2_q.zero;
    assign ones      = s2_q.ones;
    assign parity    = s2_q.parity;
    assign popcnt    = s2_q.popcnt;
    assign acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed cases plus randomized valid/ready traffic.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       use_acc;
    logic       acc_wr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       ones;
    logic       parity;
    logic [3:0] popcnt;
    logic [7:0] acc;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ones(ones), .parity(parity), .popcnt(popcnt), .acc(acc)
    );

    typedef struct {
        logic [7:0] r;
        logic       z;
        logic       o;
        logic       p;
        int         pc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       ua;
        logic       aw;
    } req_t;

    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         first_acc = -1;
    int         first_out = -1;
    int         last_out = -1;
    int         nacc = 0;
    int         vld_pct = 100;
    int         rdy_pct = 100;
    logic [7:0] macc = 8'h00;
    exp_t       q[$];
    exp_t       got[$];
    req_t       pend[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return y;
        endcase
    endfunction

    function automatic exp_t mk(input logic [7:0] r);
        exp_t e;
        e.r  = r;
        e.z  = (r == 8'h00);
        e.o  = (r == 8'hFF);
        e.p  = ^r;
        e.pc = $countones(r);
        return e;
    endfunction

    function automatic req_t rq(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] ro,
                                input logic rua, input logic raw);
        req_t r;
        r.a = ra; r.b = rb; r.op = ro; r.ua = rua; r.aw = raw;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One cycle of driving, entered at a falling edge; the reference model observes the handshake.
    task automatic step();
        req_t       r;
        logic [7:0] ae;
        logic [7:0] res;
        bit         tv;
        tv = ($urandom_range(99) < vld_pct);
        out_ready = ($urandom_range(99) < rdy_pct);
        if (pend.size() > 0 && tv) begin
            r = pend[0];
            in_valid = 1'b1; a = r.a; b = r.b; op = r.op; use_acc = r.ua; acc_wr = r.aw;
        end else begin
            r = rq(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
            in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            use_acc = 1'($urandom); acc_wr = 1'($urandom);
        end
        #4;
        chk("acc", acc, macc);
        if (in_valid && in_ready) begin
            pend.delete(0);
            nacc++;
            if (first_acc < 0) first_acc = cyc;
            ae  = r.ua ? macc : r.a;
            res = ref_op(r.op, ae, r.b);
            q.push_back(mk(res));
            if (r.aw) macc = res;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend.size() > 0 || q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        exp_t g;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                g.r = result; g.z = zero; g.o = ones; g.p = parity; g.pc = int'(popcnt);
                got.push_back(g);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", g.r, e.r);
                    chk("zero", g.z, e.z);
                    chk("ones", g.o, e.o);
                    chk("parity", g.p, e.p);
                    chk("popcnt", g.pc, e.pc);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_ops [8];
        logic [7:0] held;
        exp_ops = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'h3C};

        // Reset with a request pending
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'hA5; b = 8'h3C; op = 3'd0; use_acc = 1'b0; acc_wr = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #4;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_acc", acc, 0);
            @(negedge clk);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // All eight ops back to back
        got.delete(); first_acc = -1; first_out = -1;
        for (int i = 0; i < 8; i++) pend.push_back(rq(8'hA5, 8'h3C, 3'(i), 1'b0, 1'b0));
        drain(50);
        chk("ops_latency", first_out - first_acc, 2);
        chk("ops_throughput", last_out - first_out, 7);
        chk("ops_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("ops_value", got[i].r, exp_ops[i]);
        if (got.size() > 0) begin
            chk("flag_zero_24", got[0].z, 0);
            chk("flag_ones_24", got[0].o, 0);
            chk("flag_par_24", got[0].p, 0);
            chk("flag_pc_24", got[0].pc, 2);
        end

        // Accumulator chain
        got.delete();
        pend.push_back(rq(8'h00, 8'hF0, 3'd7, 1'b0, 1'b1));
        pend.push_back(rq(8'h00, 8'h0F, 3'd1, 1'b1, 1'b1));
        pend.push_back(rq(8'h00, 8'hFF, 3'd5, 1'b1, 1'b0));
        drain(50);
        chk("chain_acc", acc, 8'hFF);
        chk("chain_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("chain_r0", got[0].r, 8'hF0);
            chk("chain_r1", got[1].r, 8'hFF);
            chk("chain_ones1", got[1].o, 1);
            chk("chain_pc1", got[1].pc, 8);
            chk("chain_r2", got[2].r, 8'hFF);
        end

        // Backpressure: hold out_ready low for 4 cycles
        got.delete(); nacc = 0; rdy_pct = 0;
        for (int i = 0; i < 6; i++) pend.push_back(rq(8'h00, 8'(8'h10 + i), 3'd7, 1'b0, 1'b0));
        step(); step();
        held = result;
        chk("bp_s2_first", held, 8'h10);
        step(); step();
        chk("bp_accepted", nacc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_stable", result, held);
        rdy_pct = 100;
        drain(50);
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_order", got[i].r, 8'h10 + i);

        // Randomized traffic
        got.delete(); vld_pct = 70; rdy_pct = 60;
        for (int i = 0; i < 1000; i++)
            pend.push_back(rq(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)));
        drain(20000);
        chk("rand_count", got.size(), 1000);

        // Reset with both stages full and acc loaded
        vld_pct = 100; rdy_pct = 0;
        pend.push_back(rq(8'h00, 8'h55, 3'd7, 1'b0, 1'b1));
        pend.push_back(rq(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0));
        pend.push_back(rq(8'h11, 8'h22, 3'd2, 1'b0, 1'b0));
        step(); step(); step();
        chk("full_in_ready", in_ready, 0);
        chk("full_acc", acc, 8'h55);
        rst_n = 1'b0; in_valid = 1'b1;
        pend.delete(); q.delete(); macc = 8'h00;
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        got.delete(); rdy_pct = 100;
        pend.push_back(rq(8'h33, 8'h0F, 3'd2, 1'b0, 1'b0));
        drain(20);
        chk("post_mid_count", got.size(), 1);
        if (got.size() > 0) chk("post_mid_result", got[0].r, 8'h3C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
